// File: rtl/aes_inv_sbox_seq_pkg.sv
// Shared constants, state encoding and the inverse affine transform for the
// sequential AES inverse S-box.
package aes_inv_pkg;

    localparam logic [7:0]  GF_RED       = 8'h1B;
    localparam logic [7:0]  INV_AFFINE_C = 8'h05;
    localparam int unsigned EXP_STEPS    = 7;

    typedef enum logic [1:0] {
        IDLE,
        EXP,
        DONE
    } state_e;

    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/aes_inv_sbox_seq_if.sv
// Request/result bus shared with the forward S-box so one control MUX can
// drive either block.
interface aes_inv_sbox_seq_if;

    logic [7:0] value_in;
    logic       start;
    logic [7:0] value_out;
    logic       busy;
    logic       done;

    modport master (
        output value_in,
        output start,
        input  value_out,
        input  busy,
        input  done
    );

    modport slave (
        input  value_in,
        input  start,
        output value_out,
        output busy,
        output done
    );

endinterface

// File: rtl/aes_inv_sbox_seq_gf256_mul.sv
// Combinational GF(2^8) multiplier, reduction polynomial x^8+x^4+x^3+x+1.
module gf256_mul
    import aes_inv_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] partial;
    logic [7:0] shifted;

    // Shift-and-add: shifted holds a·x^i, reduced on every step.
    always_comb begin
        partial = '0;
        shifted = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                partial = partial ^ shifted;
            end
            shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? GF_RED : 8'h00);
        end
    end

    assign p = partial;

endmodule

// File: rtl/aes_inv_sbox_seq.sv
// Sequential AES inverse S-box: inverse affine, then inversion as a^254 by
// square-and-multiply over EXP_STEPS cycles.
module aes_inv_sbox_seq
    import aes_inv_pkg::*;
#(
    parameter bit DONE_PULSE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    aes_inv_sbox_seq_if.slave bus
);

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] sq_q, sq_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] value_out_q, value_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [7:0] affine_a;
    logic [7:0] sq_op;
    logic [7:0] mul_acc_p;
    logic [7:0] mul_sq_p;

    assign affine_a = inv_affine(bus.value_in);
    // The squarer doubles as the a·a seed multiplier while idle.
    assign sq_op    = (state_q == IDLE) ? affine_a : sq_q;

    gf256_mul u_mul_acc (
        .a (acc_q),
        .b (sq_q),
        .p (mul_acc_p)
    );

    gf256_mul u_mul_sq (
        .a (sq_op),
        .b (sq_op),
        .p (mul_sq_p)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sq_d        = sq_q;
        cnt_d       = cnt_q;
        value_out_d = value_out_q;
        busy_d      = busy_q;
        done_d      = done_q;
        unique case (state_q)
            IDLE: begin
                if (DONE_PULSE) begin
                    done_d = 1'b0;
                end
                if (bus.start) begin
                    sq_d    = mul_sq_p;
                    acc_d   = 8'h01;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = EXP;
                end
            end
            EXP: begin
                acc_d = mul_acc_p;
                sq_d  = mul_sq_p;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(EXP_STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                value_out_d = acc_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sq_q        <= '0;
            cnt_q       <= '0;
            value_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sq_q        <= sq_d;
            cnt_q       <= cnt_d;
            value_out_q <= value_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.value_out = value_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_inv_sbox_seq.sv
// Directed bench for aes_inv_sbox_seq; a pulse-done and a level-done instance
// receive identical stimulus.
module tb_aes_inv_sbox_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_inv_sbox_seq_if bp ();
    aes_inv_sbox_seq_if bl ();

    aes_inv_sbox_seq #(.DONE_PULSE(1'b1)) dut_p (.clk(clk), .rst(rst), .bus(bp));
    aes_inv_sbox_seq #(.DONE_PULSE(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bl));

    logic [7:0] inv_sbox [0:255] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request at a negedge; latency is -1 if done never arrives.
    task automatic issue(input logic [7:0] v, output logic [7:0] vp, output logic [7:0] vl,
                         output int lat, output logic lvl_after_accept);
        bp.value_in = v;  bl.value_in = v;
        bp.start = 1'b1;  bl.start = 1'b1;
        @(negedge clk);
        bp.start = 1'b0;  bl.start = 1'b0;
        lvl_after_accept = bl.done;
        lat = -1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bp.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        vp = bp.value_out;
        vl = bl.value_out;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bp.start = 1'b0;   bl.start = 1'b0;
        bp.value_in = '0;  bl.value_in = '0;
        #100;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (bp.value_out !== 8'h00) begin errors++; $display("FAIL reset_value_out_p got %h want 00", bp.value_out); end
        checks++; if (bp.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_p got %b want 0", bp.busy); end
        checks++; if (bp.done !== 1'b0) begin errors++; $display("FAIL reset_done_p got %b want 0", bp.done); end
        checks++; if (bl.value_out !== 8'h00) begin errors++; $display("FAIL reset_value_out_l got %h want 00", bl.value_out); end
        checks++; if (bl.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_l got %b want 0", bl.busy); end
        checks++; if (bl.done !== 1'b0) begin errors++; $display("FAIL reset_done_l got %b want 0", bl.done); end
    endtask

    task automatic test_single();
        bp.value_in = 8'h3F;  bl.value_in = 8'h3F;
        bp.start = 1'b1;      bl.start = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            bp.start = 1'b0;  bl.start = 1'b0;
            checks++; if (bp.busy !== (j < 8)) begin errors++; $display("FAIL single_busy_p cycle %0d got %b want %b", j, bp.busy, (j < 8)); end
            checks++; if (bp.done !== (j == 8)) begin errors++; $display("FAIL single_done_p cycle %0d got %b want %b", j, bp.done, (j == 8)); end
            checks++; if (bl.done !== (j == 8)) begin errors++; $display("FAIL single_done_l cycle %0d got %b want %b", j, bl.done, (j == 8)); end
        end
        checks++; if (bp.value_out !== 8'h25) begin errors++; $display("FAIL single_value_p got %h want 25", bp.value_out); end
        checks++; if (bl.value_out !== 8'h25) begin errors++; $display("FAIL single_value_l got %h want 25", bl.value_out); end
        @(negedge clk);
        checks++; if (bp.done !== 1'b0) begin errors++; $display("FAIL single_pulse_clear got %b want 0", bp.done); end
        checks++; if (bl.done !== 1'b1) begin errors++; $display("FAIL single_level_hold got %b want 1", bl.done); end
        checks++; if (bp.value_out !== 8'h25) begin errors++; $display("FAIL single_value_hold got %h want 25", bp.value_out); end
    endtask

    task automatic test_corner();
        logic [7:0] ins  [4] = '{8'h63, 8'h00, 8'h7C, 8'h16};
        logic [7:0] exps [4] = '{8'h00, 8'h52, 8'h01, 8'hFF};
        logic [7:0] vp, vl;
        logic       clr;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            issue(ins[i], vp, vl, lat, clr);
            checks++; if (lat !== 8) begin errors++; $display("FAIL corner_latency in %h got %0d want 8", ins[i], lat); end
            checks++; if (vp !== exps[i]) begin errors++; $display("FAIL corner_value_p in %h got %h want %h", ins[i], vp, exps[i]); end
            checks++; if (vl !== exps[i]) begin errors++; $display("FAIL corner_value_l in %h got %h want %h", ins[i], vl, exps[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int         d1 = -1, d2 = -1, pulses = 0;
        logic [7:0] v1 = '0, v2 = '0, l1 = '0, l2 = '0;
        logic       b1 = 1'b1, lvl10 = 1'b1;
        bp.value_in = 8'h3F;  bl.value_in = 8'h3F;
        bp.start = 1'b1;      bl.start = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (bp.done === 1'b1) begin
                pulses++;
                if (d1 < 0) begin
                    d1 = t; v1 = bp.value_out; l1 = bl.value_out; b1 = bp.busy;
                end else if (d2 < 0) begin
                    d2 = t; v2 = bp.value_out; l2 = bl.value_out;
                end
            end
            if (t == 10) lvl10 = bl.done;
            if (t == 1)  begin bp.value_in = 8'hA5; bl.value_in = 8'hA5; end
            if (t == 5)  begin bp.value_in = 8'h7C; bl.value_in = 8'h7C; end
            if (t == 10) begin bp.value_in = 8'h3F; bl.value_in = 8'h3F; end
            if (t == 18) begin bp.start = 1'b0;     bl.start = 1'b0;     end
        end
        checks++; if (d1 !== 9) begin errors++; $display("FAIL b2b_first_done_cycle got %0d want 9", d1); end
        checks++; if (v1 !== 8'h25) begin errors++; $display("FAIL b2b_first_value_p got %h want 25", v1); end
        checks++; if (l1 !== 8'h25) begin errors++; $display("FAIL b2b_first_value_l got %h want 25", l1); end
        checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done got %b want 0", b1); end
        checks++; if (d2 !== 18) begin errors++; $display("FAIL b2b_second_done_cycle got %0d want 18", d2); end
        checks++; if (v2 !== 8'h01) begin errors++; $display("FAIL b2b_second_value_p got %h want 01", v2); end
        checks++; if (l2 !== 8'h01) begin errors++; $display("FAIL b2b_second_value_l got %h want 01", l2); end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulse_count got %0d want 2", pulses); end
        checks++; if (lvl10 !== 1'b0) begin errors++; $display("FAIL b2b_level_cleared got %b want 0", lvl10); end
        checks++; if (bl.done !== 1'b1) begin errors++; $display("FAIL b2b_level_final got %b want 1", bl.done); end
        checks++; if (bp.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third got busy %b want 0", bp.busy); end
    endtask

    task automatic test_reset_mid();
        int         seen = 0;
        logic [7:0] vp, vl;
        logic       clr;
        int         lat;
        bp.value_in = 8'h3F;  bl.value_in = 8'h3F;
        bp.start = 1'b1;      bl.start = 1'b1;
        @(negedge clk);
        bp.start = 1'b0;      bl.start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (bp.value_out !== 8'h00) begin errors++; $display("FAIL midrst_value_p got %h want 00", bp.value_out); end
        checks++; if (bl.value_out !== 8'h00) begin errors++; $display("FAIL midrst_value_l got %h want 00", bl.value_out); end
        checks++; if (bp.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bp.busy); end
        checks++; if (bl.done !== 1'b0) begin errors++; $display("FAIL midrst_done_l got %b want 0", bl.done); end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bp.done === 1'b1 || bl.done === 1'b1 || bp.busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", seen); end
        issue(8'h00, vp, vl, lat, clr);
        checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_after_latency got %0d want 8", lat); end
        checks++; if (vp !== 8'h52) begin errors++; $display("FAIL midrst_after_value got %h want 52", vp); end
    endtask

    task automatic test_exhaustive();
        logic [7:0] vb, vp, vl;
        logic       clr;
        int         lat;
        for (int v = 0; v < 256; v++) begin
            vb = 8'(v);
            issue(vb, vp, vl, lat, clr);
            checks++; if (clr !== 1'b0) begin errors++; $display("FAIL exh_level_clear in %h got %b want 0", vb, clr); end
            checks++; if (lat !== 8) begin errors++; $display("FAIL exh_latency in %h got %0d want 8", vb, lat); end
            checks++; if (vp !== inv_sbox[v]) begin errors++; $display("FAIL exh_value_p in %h got %h want %h", vb, vp, inv_sbox[v]); end
            checks++; if (vl !== inv_sbox[v]) begin errors++; $display("FAIL exh_value_l in %h got %h want %h", vb, vl, inv_sbox[v]); end
            repeat (2) @(negedge clk);
            checks++; if (bl.done !== 1'b1) begin errors++; $display("FAIL exh_level_hold in %h got %b want 1", vb, bl.done); end
            checks++; if (bp.done !== 1'b0) begin errors++; $display("FAIL exh_pulse_clear in %h got %b want 0", vb, bp.done); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_corner();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_sbox_seq.md
# aes_inv_sbox_seq

Sequential AES inverse S-box: it accepts one 8-bit byte on a start pulse and returns InvSbox(byte) after a fixed multi-cycle latency. It computes the inverse affine transform followed by a GF(2^8) inversion, done as square-and-multiply exponentiation to x^254. It is the decryption-side counterpart of the forward S-box design. It shares that design's value_in/start/value_out style so both can be driven by the same control-MUX harness.

## Interface
- DONE_PULSE, 1, 1: done is a one-cycle pulse; 0: done stays high until the next accepted start.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- value_in  input  8  byte to transform; sampled only on the accepting edge.
- start  input  1  request; accepted when high at a rising edge while the block is idle.
- value_out  output  8  registered result; holds its value until the next result is written.
- busy  output  1  high while a computation is in flight.
- done  output  1  result-valid indication; value_out is valid whenever done is high.

## Operation
- Reset (rst low, asynchronous) forces:
  - state to IDLE;
  - value_out = 8'h00, busy = 0, done = 0;
  - acc, sq and cnt to 0.
- States: IDLE, EXP, DONE.
- IDLE, start = 1 at edge k:
  - a = InvAffine(value_in), where InvAffine(y) = rotl(y,1) ^ rotl(y,3) ^ rotl(y,6) ^ 8'h05;
  - sq <= a·a, acc <= 8'h01, cnt <= 0;
  - next state EXP, busy <= 1;
  - if DONE_PULSE = 0, done <= 0.
- EXP: each edge does acc <= acc·sq, sq <= sq·sq, cnt <= cnt + 1.
  - Leave for DONE when the edge performs the 7th multiply (cnt = 6 before that edge).
  - acc then equals a^254, which is a^-1 for a ≠ 0 and 0 for a = 0, with no special case.
- DONE, one edge:
  - value_out <= acc, done <= 1, busy <= 0;
  - next state IDLE.
- done clearing:
  - DONE_PULSE = 1: done <= 0 on the following edge.
  - DONE_PULSE = 0: done holds until the next accepted start.
- GF multiply:
  - polynomial product reduced modulo x^8+x^4+x^3+x+1 (reduction constant 8'h1B);
  - all operands 8 bits; no carries; XOR arithmetic only.
- start is ignored while busy (in EXP or DONE), whatever its level; it is not queued.
- value_in may change freely outside the accepting edge.

## Timing
- Latency:
  - start accepted at edge k;
  - multiplies at edges k+1 … k+7;
  - value_out and done updated at edge k+8.
  - Result visible 8 cycles after acceptance.
- busy is high from after edge k through edge k+8, and low in the cycle where done first rises.
- Back-to-back:
  - start high in the cycle where done = 1 (state IDLE) is accepted at that edge;
  - sustained throughput is one byte per 9 cycles.
- Reset mid-computation:
  - aborts immediately, asynchronously;
  - no done is produced for the aborted request;
  - value_out reads 8'h00.
- Reset deassertion:
  - synchronization is the integrator's responsibility;
  - the first accepted start may be at the first rising edge with rst high.

## Structure
- Package aes_inv_pkg holds:
  - GF_RED = 8'h1B;
  - INV_AFFINE_C = 8'h05;
  - EXP_STEPS = 7;
  - state enum {IDLE, EXP, DONE};
  - function inv_affine(8b).
- One combinational sub-module, gf256_mul (a, b → p, 8 bits).
  - Instantiated twice: acc·sq and sq·sq.
  - Squaring uses the general multiplier for reuse and verification simplicity.
- cnt is 3 bits.

## Test plan
- Reset: hold rst low 100 ns, release, idle 5 cycles → value_out = 8'h00, busy = 0, done = 0.
- Single request: value_in = 8'h3F, start pulse → done after exactly 8 cycles with value_out = 8'h25; busy high for exactly 8 cycles.
- Corner values: inputs 8'h63, 8'h00, 8'h7C, 8'h16 → 8'h00, 8'h52, 8'h01, 8'hFF. A zero after the inverse affine must yield 8'h00.
- Back-to-back and ignored start:
  - hold start high continuously with value_in alternating 8'h3F / 8'h7C → results 8'h25, 8'h01 with done 9 cycles apart;
  - value_in changes mid-EXP do not affect the result.
- Reset mid-operation: assert rst at cycle 4 of EXP → outputs zero immediately, no done. A new request for 8'h00 then returns 8'h52 normally.
- Exhaustive: all 256 inputs compared against a reference InvSbox table, with both DONE_PULSE = 1 and DONE_PULSE = 0. For DONE_PULSE = 0, check done stays high until the next accepted start.
